// File: rtl/fp_pkg.sv
// Shared sizes and the stage payload used by the FP adder normalisation stage.
// The bias constant belongs to the wider FP datapath and is kept here for it.
package fp_pkg;

    localparam int SIZE_MAN  = 28;
    localparam int SIZE_EXP  = 8;
    localparam int SIZE_LOPD = 8;
    localparam int POS_W     = $clog2(SIZE_MAN);

    localparam logic [SIZE_EXP-1:0] EXP_BIAS = SIZE_EXP'(127);

    typedef struct packed {
        logic [SIZE_MAN-1:0]  mant;
        logic [SIZE_EXP-1:0]  exp;
        logic                 sign;
        logic [SIZE_LOPD-1:0] shift;
        logic                 zero;
        logic                 ovf;
        logic                 unf;
    } norm_payload_t;

endpackage

// File: rtl/lopd_count.sv
// Combinational priority encoder: index of the most significant set bit, plus an all-zero flag.
module lopd_count #(
    parameter int W  = 28,
    parameter int PW = $clog2(W)
) (
    input  logic [W-1:0]  i_vec,
    output logic [PW-1:0] o_pos,
    output logic          o_zero
);

    always_comb begin
        o_pos  = '0;
        o_zero = 1'b1;
        // Ascending scan so the highest set bit wins.
        for (int k = 0; k < W; k++) begin
            if (i_vec[k]) begin
                o_pos  = PW'(k);
                o_zero = 1'b0;
            end
        end
    end

endmodule

// File: rtl/fp_norm_stage.sv
// Two-stage normalisation of the mantissa sum: S1 finds the leading one, S2 shifts
// and resolves the overflow/underflow/zero flags; valid/ready with full backpressure.
module fp_norm_stage
    import fp_pkg::*;
(
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_valid,
    output logic                 o_ready,
    input  logic [SIZE_MAN-1:0]  i_mant_sum,
    input  logic [SIZE_EXP-1:0]  i_exp_value,
    input  logic                 i_sign,
    output logic                 o_valid,
    input  logic                 i_ready,
    output logic [SIZE_MAN-2:0]  o_mant_norm,
    output logic [SIZE_EXP-1:0]  o_exp_value,
    output logic                 o_sign,
    output logic [SIZE_LOPD-1:0] o_lopd_value,
    output logic                 o_overflow,
    output logic                 o_underflow,
    output logic                 o_zero_flag
);

    norm_payload_t s1_q, s1_d, s2_q, s2_d;
    logic          s1_valid_q, s2_valid_q;
    logic          s2_can_load, s1_move, accept;
    logic [POS_W-1:0]    lead_pos;
    logic                lead_zero;
    logic [SIZE_MAN-2:0] mant_lo;
    logic [SIZE_EXP-1:0] clamp_amt;
    logic                unused_bits;

    assign s2_can_load = !s2_valid_q || i_ready;
    assign s1_move     = s1_valid_q && s2_can_load;
    assign o_ready     = !s1_valid_q || s2_can_load;
    assign accept      = i_valid && o_ready;

    lopd_count #(.W(SIZE_MAN), .PW(POS_W)) u_lopd (
        .i_vec  (i_mant_sum),
        .o_pos  (lead_pos),
        .o_zero (lead_zero)
    );

    always_comb begin
        s1_d       = '0;
        s1_d.mant  = i_mant_sum;
        s1_d.exp   = i_exp_value;
        s1_d.sign  = i_sign;
        s1_d.zero  = lead_zero;
        s1_d.ovf   = i_mant_sum[SIZE_MAN-1];
        if (!lead_zero && !i_mant_sum[SIZE_MAN-1]) begin
            s1_d.shift = SIZE_LOPD'(SIZE_MAN-2) - SIZE_LOPD'(lead_pos);
        end
    end

    assign mant_lo   = s1_q.mant[SIZE_MAN-2:0];
    assign clamp_amt = (s1_q.exp == '0) ? '0 : s1_q.exp - 1'b1;

    always_comb begin
        s2_d      = '0;
        s2_d.exp  = s1_q.exp;
        s2_d.sign = s1_q.sign;
        s2_d.zero = s1_q.zero;
        s2_d.ovf  = s1_q.ovf;
        if (s1_q.zero) begin
            s2_d.mant = '0;
        end else if (s1_q.ovf) begin
            s2_d.mant = {1'b0, s1_q.mant[SIZE_MAN-1:2], s1_q.mant[1] | s1_q.mant[0]};
        end else if (s1_q.shift == '0) begin
            s2_d.mant = {1'b0, mant_lo};
        end else if (s1_q.shift < SIZE_LOPD'(s1_q.exp)) begin
            s2_d.mant  = {1'b0, mant_lo << s1_q.shift};
            s2_d.shift = '0 - s1_q.shift;
        end else begin
            // Exponent cannot absorb the full shift: stop at the denormal boundary.
            s2_d.mant = {1'b0, mant_lo << clamp_amt};
            s2_d.unf  = 1'b1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            s1_valid_q <= 1'b0;
            s2_valid_q <= 1'b0;
            s1_q       <= '0;
            s2_q       <= '0;
        end else begin
            if (o_ready) s1_valid_q <= i_valid;
            if (s2_can_load) s2_valid_q <= s1_valid_q;
            if (accept) s1_q <= s1_d;
            if (s1_move) s2_q <= s2_d;
        end
    end

    assign o_valid      = s2_valid_q;
    assign o_mant_norm  = s2_q.mant[SIZE_MAN-2:0];
    assign o_exp_value  = s2_q.exp;
    assign o_sign       = s2_q.sign;
    assign o_lopd_value = s2_q.shift;
    assign o_overflow   = s2_q.ovf;
    assign o_underflow  = s2_q.unf;
    assign o_zero_flag  = s2_q.zero;

    assign unused_bits = s1_q.unf ^ s2_q.mant[SIZE_MAN-1];

endmodule

// File: tb/tb_fp_norm_stage.sv
// Scoreboard bench for fp_norm_stage: directed corner items, backpressure, reset, random traffic.
module tb_fp_norm_stage;

    typedef struct packed {
        logic [26:0] mant;
        logic [7:0]  lopd;
        logic [7:0]  e;
        logic        s;
        logic        ovf;
        logic        unf;
        logic        zero;
    } exp_t;

    logic        i_clk, i_rst_n, i_valid, o_ready, i_sign, o_valid, i_ready;
    logic [27:0] i_mant_sum;
    logic [7:0]  i_exp_value, o_exp_value, o_lopd_value;
    logic [26:0] o_mant_norm;
    logic        o_sign, o_overflow, o_underflow, o_zero_flag;

    int   checks = 0, failures = 0, cyc = 0, n_acc = 0;
    exp_t cur_exp, held, got;
    logic held_v = 1'b0, lat_chk = 1'b0, rnd_done = 1'b0;
    exp_t sbq[$];
    int   cycq[$];

    fp_norm_stage dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_valid(i_valid), .o_ready(o_ready),
        .i_mant_sum(i_mant_sum), .i_exp_value(i_exp_value), .i_sign(i_sign),
        .o_valid(o_valid), .i_ready(i_ready), .o_mant_norm(o_mant_norm),
        .o_exp_value(o_exp_value), .o_sign(o_sign), .o_lopd_value(o_lopd_value),
        .o_overflow(o_overflow), .o_underflow(o_underflow), .o_zero_flag(o_zero_flag)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;
    always @(posedge i_clk) cyc++;

    // Reference: leading-one position by repeated halving, shifts as multiplication.
    function automatic exp_t model(logic [27:0] sum, logic [7:0] e, logic s);
        exp_t   r;
        longint v, m;
        int     p, sh, amt;
        r = '0; r.e = e; r.s = s;
        v = longint'(sum); m = v; p = -1;
        while (m > 0) begin m = m / 2; p++; end
        if (p < 0) r.zero = 1'b1;
        else if (p == 27) begin
            r.ovf = 1'b1;
            r.mant = 27'((v / 2) | (v % 2));
        end else begin
            sh = 26 - p;
            if (sh == 0) r.mant = 27'(v);
            else if (sh < int'(e)) begin
                r.mant = 27'(v * (longint'(1) << sh));
                r.lopd = 8'(256 - sh);
            end else begin
                amt = (e == 0) ? 0 : int'(e) - 1;
                r.mant = 27'(v * (longint'(1) << amt));
                r.unf = 1'b1;
            end
        end
        return r;
    endfunction

    function automatic exp_t mk(logic [26:0] m, logic [7:0] l, logic [7:0] e,
                                logic o, logic u, logic z);
        exp_t r;
        r = '{mant: m, lopd: l, e: e, s: 1'b0, ovf: o, unf: u, zero: z};
        return r;
    endfunction

    assign got = {o_mant_norm, o_lopd_value, o_exp_value, o_sign, o_overflow, o_underflow, o_zero_flag};

    always @(negedge i_clk) begin
        if (!i_rst_n) begin
            sbq.delete(); cycq.delete(); held_v = 1'b0;
        end else begin
            if (held_v && o_valid) begin
                checks++;
                if (got !== held) begin
                    failures++;
                    $display("FAIL hold_stable got=%h required=%h", got, held);
                end
            end
            if (o_valid && i_ready) begin
                checks++;
                if (sbq.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_output got=%h required=none", got);
                end else begin
                    exp_t e; int c;
                    e = sbq.pop_front(); c = cycq.pop_front();
                    if (got !== e) begin
                        failures++;
                        $display("FAIL data got=%h required=%h", got, e);
                    end
                    if (lat_chk) begin
                        checks++;
                        if (cyc - c != 2) begin
                            failures++;
                            $display("FAIL latency got=%0d required=2", cyc - c);
                        end
                    end
                end
            end
            if (i_valid && o_ready) begin
                sbq.push_back(cur_exp); cycq.push_back(cyc); n_acc++;
            end
            held_v = o_valid && !i_ready;
            held = got;
        end
    end

    task automatic check1(string name, logic [31:0] act, logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s got=%h required=%h", name, act, req);
        end
    endtask

    task automatic send(logic [27:0] sum, logic [7:0] e, logic s, exp_t ex);
        int n = 0;
        cur_exp = ex; i_mant_sum = sum; i_exp_value = e; i_sign = s; i_valid = 1'b1;
        @(negedge i_clk);
        while (!o_ready && n < 100) begin @(negedge i_clk); n++; end
        if (n >= 100) check1("send_timeout", 32'(o_ready), 32'd1);
        @(posedge i_clk); #1;
    endtask

    task automatic gap(int n);
        i_valid = 1'b0;
        repeat (n) @(posedge i_clk);
        #1;
    endtask

    task automatic send_m(logic [27:0] sum, logic [7:0] e, logic s);
        send(sum, e, s, model(sum, e, s));
    endtask

    function automatic logic [27:0] rnd_sum();
        int p;
        case ($urandom_range(0, 5))
            0: return 28'h0;
            1: return {1'b1, 27'($urandom)};
            2: return {2'b01, 26'($urandom)};
            default: begin
                p = $urandom_range(0, 25);
                return (28'(1) << p) | (28'($urandom) & ((28'(1) << p) - 28'(1)));
            end
        endcase
    endfunction

    function automatic logic [7:0] rnd_exp();
        return ($urandom_range(0, 1) == 1) ? 8'($urandom_range(0, 30)) : 8'($urandom);
    endfunction

    initial begin
        int acc0, stale, n;
        i_rst_n = 1'b0; i_valid = 1'b0; i_ready = 1'b0;
        i_mant_sum = '0; i_exp_value = '0; i_sign = 1'b0; cur_exp = '0;
        repeat (2) @(posedge i_clk);
        #1;
        check1("reset_valid", 32'(o_valid), 32'd0);
        i_rst_n = 1'b1; i_ready = 1'b1;
        @(negedge i_clk);
        check1("reset_ready", 32'(o_ready), 32'd1);
        check1("reset_mant", 32'(o_mant_norm), 32'd0);
        check1("reset_flags", {29'd0, o_overflow, o_underflow, o_zero_flag}, 32'd0);
        @(posedge i_clk); #1;

        lat_chk = 1'b1;
        send(28'h4000000, 8'h80, 1'b0, mk(27'h4000000, 8'h00, 8'h80, 0, 0, 0)); gap(3);
        send(28'h8000001, 8'h80, 1'b0, mk(27'h4000001, 8'h00, 8'h80, 1, 0, 0)); gap(3);
        send(28'h0000100, 8'h80, 1'b0, mk(27'h4000000, 8'hEE, 8'h80, 0, 0, 0)); gap(3);
        send(28'h0000100, 8'h05, 1'b0, mk(27'h0001000, 8'h00, 8'h05, 0, 1, 0)); gap(3);
        send(28'h0000000, 8'h7F, 1'b0, mk(27'h0000000, 8'h00, 8'h7F, 0, 0, 1)); gap(3);
        send(28'h0000100, 8'h12, 1'b0, mk(27'h2000000, 8'h00, 8'h12, 0, 1, 0)); gap(3);
        send(28'h0000100, 8'h13, 1'b0, mk(27'h4000000, 8'hEE, 8'h13, 0, 0, 0)); gap(3);
        send(28'h0000100, 8'h00, 1'b0, mk(27'h0000100, 8'h00, 8'h00, 0, 1, 0)); gap(3);
        send(28'h4000000, 8'h00, 1'b0, mk(27'h4000000, 8'h00, 8'h00, 0, 0, 0)); gap(3);
        for (int k = 0; k < 6; k++) send_m(rnd_sum(), rnd_exp(), 1'($urandom));
        gap(4);
        lat_chk = 1'b0;

        i_ready = 1'b0;
        acc0 = n_acc;
        fork
            begin
                for (int k = 0; k < 4; k++) send_m(rnd_sum(), rnd_exp(), 1'($urandom));
            end
            begin
                repeat (5) @(posedge i_clk);
                #1;
                check1("bp_accepted", 32'(n_acc - acc0), 32'd2);
                check1("bp_ready_low", 32'(o_ready), 32'd0);
                i_ready = 1'b1;
            end
        join
        gap(6);
        check1("bp_drained", 32'(sbq.size()), 32'd0);

        for (int k = 0; k < 3; k++) send_m(rnd_sum(), rnd_exp(), 1'($urandom));
        i_valid = 1'b0;
        i_rst_n = 1'b0;
        #1;
        check1("rst_mid_valid", 32'(o_valid), 32'd0);
        repeat (2) @(posedge i_clk);
        #1;
        i_rst_n = 1'b1;
        stale = 0;
        repeat (10) begin @(negedge i_clk); if (o_valid) stale++; end
        check1("rst_no_stale", 32'(stale), 32'd0);
        @(posedge i_clk); #1;

        fork
            begin
                while (!rnd_done) begin
                    @(posedge i_clk); #1;
                    i_ready = ($urandom_range(0, 3) != 0);
                end
                i_ready = 1'b1;
            end
            begin
                for (int k = 0; k < 300; k++) begin
                    send_m(rnd_sum(), rnd_exp(), 1'($urandom));
                    if ($urandom_range(0, 3) == 0) gap($urandom_range(1, 3));
                end
                i_valid = 1'b0;
                rnd_done = 1'b1;
            end
        join
        n = 0;
        while (sbq.size() != 0 && n < 500) begin @(negedge i_clk); n++; end
        check1("final_drain", 32'(sbq.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
